// File: rtl/systolic_feeder.sv
// Skews two captured square operand matrices into diagonal, zero-padded edge streams for systolic_array.
// Optional FEEDER_DIM_MASK_EN: zero elements outside the active dim_n x dim_n sub-matrix.
module systolic_feeder #(
  parameter  int data_width = 32,
  parameter  int bus_width  = 64,
  localparam int max_dim    = bus_width / data_width
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_bit,
  input  logic [max_dim*max_dim*data_width-1:0] operand_a,
  input  logic [max_dim*max_dim*data_width-1:0] operand_b,
  input  logic [$clog2(max_dim):0]              dim_n,
  output logic [max_dim*data_width-1:0]         a_out,
  output logic [max_dim*data_width-1:0]         b_out,
  output logic                                  done_paddign,
  output logic                                  busy,
  output logic                                  feed_done
);

  localparam int MAT_W  = max_dim * max_dim * data_width;
  localparam int LANE_W = max_dim * data_width;
  localparam int CNT_W  = (max_dim > 1) ? $clog2(2 * max_dim) : 1;
  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(2 * max_dim - 2);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(max_dim - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAT_W-1:0]   cap_a_q, cap_a_d;
  logic [MAT_W-1:0]   cap_b_q, cap_b_d;
  logic [LANE_W-1:0]  a_out_q, a_out_d;
  logic [LANE_W-1:0]  b_out_q, b_out_d;
  logic               pad_q, pad_d;
  logic               busy_q, busy_d;
  logic               feed_done_q, feed_done_d;
  int                 dim_eff;

`ifdef FEEDER_DIM_MASK_EN
  always_comb begin
    dim_eff = max_dim;
    if ((dim_n != '0) && (int'(dim_n) <= max_dim)) dim_eff = int'(dim_n);
  end
`else
  logic unused_dim;
  assign unused_dim = ^dim_n;
  assign dim_eff    = max_dim;
`endif

  // Lane i carries A[i][t-i]; anything off the matrix or outside the active dimension is zero.
  function automatic logic [LANE_W-1:0] slice_a(input logic [MAT_W-1:0] m, input int t, input int dim);
    logic [LANE_W-1:0] v;
    int                k;
    v = '0;
    for (int i = 0; i < max_dim; i++) begin
      k = t - i;
      if ((k >= 0) && (k < max_dim) && (i < dim) && (k < dim))
        v[data_width*i +: data_width] = m[data_width*(i*max_dim+k) +: data_width];
    end
    return v;
  endfunction

  // Lane j carries B[t-j][j].
  function automatic logic [LANE_W-1:0] slice_b(input logic [MAT_W-1:0] m, input int t, input int dim);
    logic [LANE_W-1:0] v;
    int                k;
    v = '0;
    for (int j = 0; j < max_dim; j++) begin
      k = t - j;
      if ((k >= 0) && (k < max_dim) && (j < dim) && (k < dim))
        v[data_width*j +: data_width] = m[data_width*(k*max_dim+j) +: data_width];
    end
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_a_d     = cap_a_q;
    cap_b_d     = cap_b_q;
    a_out_d     = '0;
    b_out_d     = '0;
    pad_d       = 1'b0;
    feed_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_bit) begin
          cap_a_d = operand_a;
          cap_b_d = operand_b;
          cnt_d   = '0;
          state_d = STREAM;
          a_out_d = slice_a(operand_a, 0, dim_eff);
          b_out_d = slice_b(operand_b, 0, dim_eff);
          pad_d   = 1'b1;
        end
      end
      STREAM: begin
        pad_d = 1'b1;
        if (cnt_q == STREAM_LAST) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          a_out_d = slice_a(cap_a_q, int'(cnt_q) + 1, dim_eff);
          b_out_d = slice_b(cap_b_q, int'(cnt_q) + 1, dim_eff);
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d       = '0;
          state_d     = DONE;
          feed_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          pad_d = 1'b1;
        end
      end
      DONE: begin
        // Wait for the request level to drop so a held start_bit cannot retrigger.
        if (!start_bit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      pad_q       <= 1'b0;
      busy_q      <= 1'b0;
      feed_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      pad_q       <= pad_d;
      busy_q      <= busy_d;
      feed_done_q <= feed_done_d;
    end
  end

  assign a_out        = a_out_q;
  assign b_out        = b_out_q;
  assign done_paddign = pad_q;
  assign busy         = busy_q;
  assign feed_done    = feed_done_q;

endmodule
